// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared MIDI types and constants
// Purpose: receiver state encoding, MIDI line constants, majority-vote helper.
// Ports: none (package).
package midi_pkg;

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int         MIDI_BAUD            = 31250;
  localparam int         DEFAULT_CLKS_PER_BIT = 384;
  localparam logic [7:0] MIDI_STATUS_MASK     = 8'h80;

  // Two-of-three vote over the mid-bit samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop synchroniser for an asynchronous input
// Purpose: brings an asynchronous level into the clk domain; flops reset to 1.
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset
//   d    in   asynchronous input
//   q    out  synchronised output (SYNC_STAGES clocks of latency)
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic [SYNC_STAGES-1:0] chain_d;

  always_comb begin
    chain_d    = chain_q << 1;
    chain_d[0] = d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '1;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/midi_uart_rx.sv
// rtl/midi_uart_rx.sv - oversampling 8N1 MIDI byte receiver
// Purpose: recovers bytes from the MIDI line with a 3-sample majority vote
//   per bit, forwards good bytes as a one-cycle strobe, drops bad-stop bytes.
// Ports:
//   clk             in   system clock
//   rst             in   synchronous active-high reset
//   rx_in           in   raw asynchronous MIDI line, idle high
//   new_byte_valid  out  one-cycle pulse, new_byte_value holds a good byte
//   new_byte_value  out  last good byte, held until the next good byte
//   framing_error   out  one-cycle pulse, stop bit sampled low
//   busy            out  high while a frame is being received
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic       new_byte_valid,
  output logic [7:0] new_byte_value,
  output logic       framing_error,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
  localparam logic [CW-1:0] CNT_DEC  = CW'(HALF + 1);

  if ((CLKS_PER_BIT % 2) != 0 || CLKS_PER_BIT < 8) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be even and >= 8");
  end

  logic rx_s;

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx_in),
    .q  (rx_s)
  );

  rx_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       s0_q, s0_d;
  logic       s1_q, s1_d;
  logic       rx_prev_q, rx_prev_d;
  logic [7:0] value_q, value_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;

  logic decide;
  logic maj;

  // The third sample is the live rx_s at the decision count.
  assign decide = (cnt_q == CNT_DEC);
  assign maj    = maj3(s0_q, s1_q, rx_s);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARM;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      rx_prev_q <= 1'b1;
      value_q   <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      rx_prev_q <= rx_prev_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARM: begin
        if (rx_s && cnt_q == CNT_LAST) state_d = IDLE;
      end
      IDLE: begin
        // Edge, not level: a line already low cannot start a frame.
        if (rx_prev_q && !rx_s) state_d = START;
      end
      START: begin
        if (decide) state_d = maj ? IDLE : DATA;
      end
      DATA: begin
        if (decide && bit_idx_q == 3'd7) state_d = STOP;
      end
      STOP: begin
        // Leaving at mid-stop lets a start edge right after the stop bit be seen.
        if (decide) state_d = maj ? IDLE : ARM;
      end
      default: state_d = ARM;
    endcase
  end

  // Datapath and output logic.
  always_comb begin
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    rx_prev_d = rx_s;
    value_d   = value_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ARM: begin
        // cnt counts consecutive high samples here; any low restarts it.
        if (!rx_s || cnt_q == CNT_LAST) cnt_d = '0;
        else                            cnt_d = cnt_q + CNT_ONE;
      end
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
      end
      START, DATA, STOP: begin
        busy  = 1'b1;
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
        if (cnt_q == CNT_S0) s0_d = rx_s;
        if (cnt_q == CNT_S1) s1_d = rx_s;
        if (decide && state_q == DATA) begin
          shift_d[bit_idx_q] = maj;
          bit_idx_d          = bit_idx_q + 3'd1;
        end
        if (decide && state_q == STOP) begin
          if (maj) begin
            value_d = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
            cnt_d  = '0;
          end
        end
      end
      default: ;
    endcase
  end

  assign new_byte_valid = valid_q;
  assign new_byte_value = value_q;
  assign framing_error  = ferr_q;

endmodule

// File: tb/tb_midi_uart_rx.sv
// tb/tb_midi_uart_rx.sv - randomized self-checking bench for midi_uart_rx
module tb_midi_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic       new_byte_valid;
  logic [7:0] new_byte_value;
  logic       framing_error;
  logic       busy;

  midi_uart_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_in         (rx_in),
    .new_byte_valid(new_byte_valid),
    .new_byte_value(new_byte_value),
    .framing_error (framing_error),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;
  int cyc;
  int both_hi;
  logic busy_seen;
  logic [7:0] last_val;

  // Observed and expected event streams: kind 1 = good byte, 2 = framing error.
  int         ev_kind[$];
  logic [7:0] ev_val[$];
  int         ev_cyc[$];
  int         exp_kind[$];
  logic [7:0] exp_val[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (new_byte_valid) begin
        ev_kind.push_back(1);
        ev_val.push_back(new_byte_value);
        ev_cyc.push_back(cyc);
      end
      if (framing_error) begin
        ev_kind.push_back(2);
        ev_val.push_back(8'h00);
        ev_cyc.push_back(cyc);
      end
      if (new_byte_valid && framing_error) both_hi++;
      if (busy) busy_seen = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    rx_in = 1'b1;
    repeat (n * CPB) tick();
  endtask

  // One 8N1 frame. gl_slot/gl_off invert the line for one clock inside a bit
  // slot (slot 0 = start, 1..8 = data, 9 = stop); rst_slot pulses rst at mid-slot.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int gl_slot, input int gl_off, input int rst_slot);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int s = 0; s < 10; s++) begin
      for (int c = 0; c < CPB; c++) begin
        rx_in = bits[s] ^ ((s == gl_slot) && (c == gl_off));
        rst   = (s == rst_slot) && (c == HALF);
        tick();
        if (rst) begin
          rst = 1'b0;
          check("rst_valid", new_byte_valid, 0);
          check("rst_ferr",  framing_error, 0);
          check("rst_busy",  busy, 0);
          check("rst_value", new_byte_value, 8'h00);
        end
      end
    end
    if (rst_slot >= 0) begin
      last_val = 8'h00;
    end else if (stop_bit) begin
      exp_kind.push_back(1);
      exp_val.push_back(b);
      last_val = b;
    end else begin
      exp_kind.push_back(2);
      exp_val.push_back(8'h00);
    end
  endtask

  task automatic compare_events(input string tag);
    int n;
    check({tag, "_count"}, ev_kind.size(), exp_kind.size());
    n = (ev_kind.size() < exp_kind.size()) ? ev_kind.size() : exp_kind.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_kind"}, ev_kind[i], exp_kind[i]);
      check({tag, "_val"},  ev_val[i],  exp_val[i]);
    end
    ev_kind.delete();
    ev_val.delete();
    ev_cyc.delete();
    exp_kind.delete();
    exp_val.delete();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    both_hi      = 0;
    busy_seen    = 1'b0;
    last_val     = 8'h00;
    rst          = 1'b1;
    rx_in        = 1'b1;
    repeat (3) tick();
    check("reset_valid", new_byte_valid, 0);
    check("reset_value", new_byte_value, 8'h00);
    check("reset_ferr",  framing_error, 0);
    check("reset_busy",  busy, 0);
    rst = 1'b0;
    idle_bits(2);

    // 1: single byte
    send_frame(8'h90, 1'b1, -1, 0, -1);
    idle_bits(2);
    compare_events("t1");
    check("t1_busy",  busy, 0);
    check("t1_value", new_byte_value, last_val);

    // 2: back-to-back frames with one-bit stops
    send_frame(8'h90, 1'b1, -1, 0, -1);
    send_frame(8'h3C, 1'b1, -1, 0, -1);
    send_frame(8'h64, 1'b1, -1, 0, -1);
    idle_bits(2);
    if (ev_cyc.size() >= 3) begin
      check("t2_gap01", ev_cyc[1] - ev_cyc[0], 10 * CPB);
      check("t2_gap12", ev_cyc[2] - ev_cyc[1], 10 * CPB);
    end
    compare_events("t2");

    // 3: short low glitch on idle line is a false start
    busy_seen = 1'b0;
    rx_in = 1'b0;
    repeat (3) tick();
    idle_bits(3);
    check("t3_busy_seen", busy_seen, 1);
    check("t3_busy", busy, 0);
    compare_events("t3");

    // 4: framing error, long break, recovery
    send_frame(8'h00, 1'b0, -1, 0, -1);
    rx_in = 1'b0;
    repeat (40 * CPB) tick();
    compare_events("t4_break");
    check("t4_value_held", new_byte_value, last_val);
    idle_bits(2);
    send_frame(8'h80, 1'b1, -1, 0, -1);
    idle_bits(2);
    compare_events("t4_recover");
    check("t4_value", new_byte_value, 8'h80);

    // 5: single-clock inversion at mid data bit 3 is voted out
    send_frame(8'hA5, 1'b1, 4, HALF + 1, -1);
    idle_bits(2);
    compare_events("t5");

    // 6: reset in the middle of data bit 2
    send_frame(8'h00, 1'b0, -1, 0, 3);
    idle_bits(2);
    compare_events("t6_abort");
    check("t6_value_after_rst", new_byte_value, 8'h00);
    send_frame(8'h55, 1'b1, -1, 0, -1);
    idle_bits(2);
    compare_events("t6_next");

    // Random bytes, random stop quality, random single-sample glitch
    for (int k = 0; k < 12; k++) begin
      logic [7:0] rb;
      logic       rs;
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rb, rs, int'($urandom_range(1, 8)), HALF + int'($urandom_range(0, 2)), -1);
      idle_bits(2);
      compare_events("rnd");
      check("rnd_value", new_byte_value, last_val);
    end

    check("never_both", both_hi, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
